// File: rtl/stim_regbank_axil.sv
// AXI4-Lite register bank: one write-pulse register, a block of read/write
// control registers and a block of read-only live status registers.
module stim_regbank_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 16,
    parameter int NUM_STATUS         = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [(NUM_REGS-NUM_STATUS-1)*C_S_AXI_DATA_WIDTH-1:0] ctrl_q,
    input  logic [NUM_STATUS*C_S_AXI_DATA_WIDTH-1:0]              status_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          pulse_o
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int NUM_CTRL = NUM_REGS - NUM_STATUS - 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    function automatic logic [31:0] word_idx(input logic [AW-1:0] a);
        return 32'(a >> ADDR_LSB);
    endfunction

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [AW-1:0]     aw_addr_q, aw_addr_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [NB-1:0]     w_strb_q, w_strb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     pulse_q, pulse_d;
    logic [DW-1:0]     ctrl_mem_q [NUM_CTRL];
    logic [DW-1:0]     ctrl_mem_d [NUM_CTRL];

    logic              commit;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_data;
    logic [NB-1:0]     c_strb;
    logic [DW-1:0]     c_mask;
    logic [31:0]       c_idx;
    logic [31:0]       r_idx;

    logic              unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        commit    = 1'b0;
        c_addr    = S_AXI_AWADDR;
        c_data    = S_AXI_WDATA;
        c_strb    = S_AXI_WSTRB;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    aw_addr_d = S_AXI_AWADDR;
                    w_state_d = W_HAVE_AW;
                end else if (S_AXI_WVALID) begin
                    w_data_d  = S_AXI_WDATA;
                    w_strb_d  = S_AXI_WSTRB;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                c_addr = aw_addr_q;
                if (S_AXI_WVALID) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                c_data = w_data_q;
                c_strb = w_strb_q;
                if (S_AXI_AWVALID) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Commit path: byte-lane merge into control words, pulse strobes for index 0
    always_comb begin
        ctrl_mem_d = ctrl_mem_q;
        pulse_d    = '0;
        bresp_d    = bresp_q;
        c_idx      = word_idx(c_addr);
        c_mask     = '0;
        for (int b = 0; b < NB; b++) c_mask[b*8 +: 8] = {8{c_strb[b]}};
        if (commit) begin
            bresp_d = (c_idx > 32'(NUM_CTRL)) ? RESP_SLVERR : RESP_OKAY;
            if (c_idx == 32'd0) pulse_d = c_data & c_mask;
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (c_idx == 32'(k + 1))
                    ctrl_mem_d[k] = (ctrl_mem_q[k] & ~c_mask) | (c_data & c_mask);
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_idx     = word_idx(S_AXI_ARADDR);
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = (r_idx >= 32'(NUM_REGS)) ? RESP_SLVERR : RESP_OKAY;
                    for (int k = 0; k < NUM_CTRL; k++)
                        if (r_idx == 32'(k + 1)) rdata_d = ctrl_mem_q[k];
                    for (int j = 0; j < NUM_STATUS; j++)
                        if (r_idx == 32'(NUM_CTRL + 1 + j)) rdata_d = status_in[j*DW +: DW];
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int k = 0; k < NUM_CTRL; k++) ctrl_mem_q[k] <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            pulse_q    <= pulse_d;
            ctrl_mem_q <= ctrl_mem_d;
        end
    end

    // Half-transaction holding registers; stale contents are unreachable after reset
    always_ff @(posedge S_AXI_ACLK) begin
        aw_addr_q <= aw_addr_d;
        w_data_q  <= w_data_d;
        w_strb_q  <= w_strb_d;
    end

    assign S_AXI_AWREADY = !S_AXI_ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_W);
    assign S_AXI_WREADY  = !S_AXI_ARESET && (w_state_q == W_IDLE || w_state_q == W_HAVE_AW);
    assign S_AXI_BVALID  = !S_AXI_ARESET && (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !S_AXI_ARESET && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = !S_AXI_ARESET && (r_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign pulse_o       = pulse_q;

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
        assign ctrl_q[k*DW +: DW] = ctrl_mem_q[k];
    end

endmodule

// File: tb/tb_stim_regbank_axil.sv
// Directed bench for stim_regbank_axil; B/R responses checked by a queue-based monitor.
module tb_stim_regbank_axil;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam int NS = 4;
    localparam int NC = NR - NS - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DW-1:0]     wdata, rdata, pulse_o;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic [NC*DW-1:0]  ctrl_q;
    logic [NS*DW-1:0]  status_in;

    always #5 clk = ~clk;

    stim_regbank_axil #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR), .NUM_STATUS(NS)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_q(ctrl_q), .status_in(status_in), .pulse_o(pulse_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t      rd_q[$];
    logic [1:0]   wr_q[$];
    rd_exp_t      mon_rexp;
    logic [1:0]   mon_bexp;
    logic [31:0]  pulse_at_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_word(input int k);
        return ctrl_q[(k-1)*DW +: DW];
    endfunction

    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (wr_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL bresp_unexpected: got 0x%0h expected no response", bresp);
            end else begin
                mon_bexp = wr_q.pop_front();
                check("bresp", 32'(bresp), 32'(mon_bexp));
            end
        end
        if (rvalid && rready) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL r_unexpected: got 0x%0h expected no response", rdata);
            end else begin
                mon_rexp = rd_q.pop_front();
                check("rdata", rdata, mon_rexp.data);
                check("rresp", 32'(rresp), 32'(mon_rexp.resp));
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        int cyc = 0;
        wr_q.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((aw_pend || w_pend) && cyc < 20) begin
            @(negedge clk);
            if (awvalid && awready) aw_pend = 1'b0;
            if (wvalid && wready)   w_pend  = 1'b0;
            @(posedge clk); #1;
            if (!aw_pend) awvalid = 1'b0;
            if (!w_pend)  wvalid  = 1'b0;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (aw_pend || w_pend) begin
            n_tests++; n_fail++;
            $display("FAIL write_handshake_timeout: got no handshake expected AW/W accepted");
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bvalid && cyc < 20);
        if (!bvalid) begin
            n_tests++; n_fail++;
            $display("FAIL bvalid_timeout: got 0 expected 1");
        end
        pulse_at_b = pulse_o;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        bit ar_pend = 1'b1;
        int cyc = 0;
        rd_q.push_back({exp_data, exp_resp});
        araddr = addr; arvalid = 1'b1;
        while (ar_pend && cyc < 20) begin
            @(negedge clk);
            if (arvalid && arready) ar_pend = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (ar_pend) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: got no handshake expected AR accepted");
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rvalid && cyc < 20);
        if (!rvalid) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        status_in = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readies", 32'({awready, wready, arready}), 32'd0);
        check("reset_valids", 32'({bvalid, rvalid}), 32'd0);
        check("reset_ctrl_or", 32'(|ctrl_q), 32'd0);
        check("reset_pulse", pulse_o, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_readies", 32'({awready, wready, arready}), 32'b111);
        @(posedge clk); #1;

        // Basic write/readback of four control words
        for (int i = 1; i <= 4; i++) axi_write(AW'(4*i), 32'(i), 4'hF, 2'b00);
        for (int i = 1; i <= 4; i++) axi_read(AW'(4*i), 32'(i), 2'b00);
        for (int i = 1; i <= 4; i++) check("ctrl_word", ctrl_word(i), 32'(i));

        // Partial strobe merge; low byte-offset bits ignored on read
        axi_write(7'h04, 32'hAABBCCDD, 4'hF, 2'b00);
        axi_write(7'h04, 32'h11223344, 4'b0101, 2'b00);
        axi_read(7'h07, 32'hAA22CC44, 2'b00);
        check("ctrl1_strobe", ctrl_word(1), 32'hAA22CC44);
        axi_write(7'h08, 32'hFFFFFFFF, 4'b0000, 2'b00);
        check("ctrl2_nostrobe", ctrl_word(2), 32'h2);

        // Pulse register
        axi_write(7'h00, 32'h00000005, 4'hF, 2'b00);
        check("pulse_after_commit", pulse_at_b, 32'h5);
        @(negedge clk);
        check("pulse_one_cycle", pulse_o, 32'h0);
        @(posedge clk); #1;
        axi_write(7'h00, 32'h00000F0F, 4'b0001, 2'b00);
        check("pulse_strobed", pulse_at_b, 32'h0F);
        axi_read(7'h00, 32'h0, 2'b00);

        // W three cycles ahead of AW, response held off by BREADY
        bready = 1'b0;
        wr_q.push_back(2'b00);
        awaddr = 7'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("w_first_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("have_w_readies", 32'({awready, wready, bvalid}), 32'b100);
            @(posedge clk); #1;
        end
        awvalid = 1'b1;
        @(negedge clk);
        check("aw_late_ready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("ctrl2_late_aw", ctrl_word(2), 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("resp_hold", 32'({bvalid, bresp, awready, wready}), 32'b10000);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_cleared", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        axi_read(7'h08, 32'hCAFEF00D, 2'b00);

        // Status region, last control word and out-of-range index
        status_in = {32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678};
        axi_write(7'h30, 32'hFFFFFFFF, 4'hF, 2'b10);
        axi_read(7'h30, 32'h12345678, 2'b00);
        axi_read(7'h3C, 32'hDEADBEEF, 2'b00);
        axi_read(7'h40, 32'h0, 2'b10);
        axi_write(7'h40, 32'h12121212, 4'hF, 2'b10);
        axi_write(7'h2C, 32'h0BADCAFE, 4'hF, 2'b00);
        axi_read(7'h2C, 32'h0BADCAFE, 2'b00);
        check("ctrl11", ctrl_word(NC), 32'h0BADCAFE);
        check("ctrl1_unchanged", ctrl_word(1), 32'hAA22CC44);

        // Reset between AW and W
        awaddr = 7'h08; awvalid = 1'b1;
        @(negedge clk);
        check("aw_before_reset", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("after_mid_reset", 32'({awready, wready, bvalid}), 32'b110);
            @(posedge clk); #1;
        end
        check("ctrl_cleared", 32'(|ctrl_q), 32'd0);
        axi_write(7'h0C, 32'h00000077, 4'hF, 2'b00);
        axi_read(7'h0C, 32'h00000077, 2'b00);

        // Read captured on the same edge as a commit to that word sees the old value
        fork
            axi_write(7'h0C, 32'h00000088, 4'hF, 2'b00);
            axi_read(7'h0C, 32'h00000077, 2'b00);
        join
        axi_read(7'h0C, 32'h00000088, 2'b00);

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(rd_q.size() + wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
